// File: rtl/alu_pkg.sv
// Shared constants, buffer state encoding and entry payload for the ALU execute stage.
package alu_pkg;

  localparam int unsigned WIDTH  = 64;
  localparam int unsigned TAG_W  = 5;
  localparam int unsigned CTRL_W = 4;

  localparam logic [CTRL_W-1:0] ALU_AND = 4'b0000;
  localparam logic [CTRL_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [CTRL_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [CTRL_W-1:0] ALU_SUB = 4'b0110;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_e;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             illegal;
    logic [TAG_W-1:0] rd;
  } alu_entry_t;

endpackage

// File: rtl/alu_exec_stage_if.sv
// Upstream op channel and downstream result channel of the execute stage.
interface alu_exec_stage_if;
  import alu_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_alu_control;
  logic [WIDTH-1:0]  in_operand_a;
  logic [WIDTH-1:0]  in_operand_b;
  logic [TAG_W-1:0]  in_rd;

  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_result;
  logic              out_zero;
  logic              out_illegal;
  logic [TAG_W-1:0]  out_rd;

  // Stage view: consumes ops, produces results.
  modport slave (
    input  in_valid, in_alu_control, in_operand_a, in_operand_b, in_rd, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_illegal, out_rd
  );

  // Environment view: issues ops, consumes results.
  modport master (
    output in_valid, in_alu_control, in_operand_a, in_operand_b, in_rd, out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_illegal, out_rd
  );

endinterface

// File: rtl/alu_core.sv
// Combinational ALU: AND/OR/ADD/SUB with zero and unsupported-code flags.
module alu_core
  import alu_pkg::*;
(
  input  logic [CTRL_W-1:0] alu_control,
  input  logic [WIDTH-1:0]  operand_a,
  input  logic [WIDTH-1:0]  operand_b,
  output logic [WIDTH-1:0]  result_c,
  output logic              zero_c,
  output logic              illegal_c
);

  always_comb begin
    result_c  = '0;
    illegal_c = 1'b0;
    case (alu_control)
      ALU_AND: result_c = operand_a & operand_b;
      ALU_OR:  result_c = operand_a | operand_b;
      ALU_ADD: result_c = WIDTH'(operand_a + operand_b);
      ALU_SUB: result_c = WIDTH'(operand_a - operand_b);
      default: illegal_c = 1'b1;
    endcase
    zero_c = (result_c == '0);
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Execute stage: ALU core feeding a 2-entry (output + skid) buffer with valid/ready on both sides.
module alu_exec_stage
  import alu_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  alu_exec_stage_if.slave  bus
);

  buf_state_e state_q, state_d;
  alu_entry_t out_q, out_d;
  alu_entry_t skid_q, skid_d;
  alu_entry_t new_entry;
  logic       accept;
  logic       pop;

  alu_core u_alu_core (
    .alu_control (bus.in_alu_control),
    .operand_a   (bus.in_operand_a),
    .operand_b   (bus.in_operand_b),
    .result_c    (new_entry.result),
    .zero_c      (new_entry.zero),
    .illegal_c   (new_entry.illegal)
  );
  assign new_entry.rd = bus.in_rd;

  // in_ready depends only on registered state, never on out_ready.
  assign bus.in_ready  = (state_q != FULL) && !reset;
  assign bus.out_valid = (state_q != EMPTY);
  assign bus.out_result  = out_q.result;
  assign bus.out_zero    = out_q.zero;
  assign bus.out_illegal = out_q.illegal;
  assign bus.out_rd      = out_q.rd;

  assign accept = bus.in_valid && bus.in_ready;
  assign pop    = bus.out_valid && bus.out_ready;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          out_d   = new_entry;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && pop) begin
          out_d = new_entry;
        end else if (accept) begin
          skid_d  = new_entry;
          state_d = FULL;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          out_d   = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Scoreboard bench for alu_exec_stage: capacity-2 FIFO model plus behavioural ALU reference.
module tb_alu_exec_stage;
  import alu_pkg::*;

  typedef struct {
    logic [63:0] res;
    logic        z;
    logic        il;
    logic [4:0]  rd;
  } exp_t;

  logic clock;
  logic reset;
  logic rand_bp;
  int   checks;
  int   failures;
  int   pushes;
  int   pops;
  exp_t sb[$];

  alu_exec_stage_if bus ();

  alu_exec_stage dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [3:0] c, input logic [63:0] a, input logic [63:0] b,
                                 input logic [4:0] rd);
    exp_t e;
    e.rd = rd;
    e.il = 1'b0;
    case (c)
      4'b0000: e.res = a & b;
      4'b0001: e.res = a | b;
      4'b0010: e.res = a + b;
      4'b0110: e.res = a - b;
      default: begin e.res = 64'd0; e.il = 1'b1; end
    endcase
    e.z = (e.res == 64'd0);
    return e;
  endfunction

  function automatic exp_t mk(input logic [63:0] res, input logic z, input logic il, input logic [4:0] rd);
    exp_t e;
    e.res = res; e.z = z; e.il = il; e.rd = rd;
    return e;
  endfunction

  // Monitor: the buffer must look like a 2-deep FIFO of accepted ops, head presented on the outputs.
  always begin
    @(negedge clock);
    #1;
    if (!reset) begin
      chk("out_valid", 64'(bus.out_valid), 64'(sb.size() != 0));
      chk("in_ready", 64'(bus.in_ready), 64'(sb.size() < 2));
      if (bus.out_valid && sb.size() != 0) begin
        chk("out_result", bus.out_result, sb[0].res);
        chk("out_zero", 64'(bus.out_zero), 64'(sb[0].z));
        chk("out_illegal", 64'(bus.out_illegal), 64'(sb[0].il));
        chk("out_rd", 64'(bus.out_rd), 64'(sb[0].rd));
        if (bus.out_ready) begin
          void'(sb.pop_front());
          pops++;
        end
      end
    end
  end

  always @(negedge clock) if (rand_bp) bus.out_ready = 1'($urandom_range(0, 1));

  // Starts and ends on a falling edge; in_valid is left high for back-to-back issue.
  task automatic send(input logic [3:0] c, input logic [63:0] a, input logic [63:0] b,
                      input logic [4:0] rd, input exp_t e, input int budget);
    int n;
    n = 0;
    bus.in_valid       = 1'b1;
    bus.in_alu_control = c;
    bus.in_operand_a   = a;
    bus.in_operand_b   = b;
    bus.in_rd          = rd;
    forever begin
      #2;
      if (bus.in_ready && !reset) begin
        sb.push_back(e);
        pushes++;
        @(negedge clock);
        break;
      end
      n++;
      if (n > budget) begin
        chk("accept_timeout", 64'(n), 64'(budget));
        @(negedge clock);
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic send_rand(input int budget);
    logic [3:0]  c;
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  rd;
    logic [3:0]  codes [5];
    codes[0] = ALU_AND; codes[1] = ALU_OR; codes[2] = ALU_ADD; codes[3] = ALU_SUB;
    codes[4] = 4'($urandom);
    c  = codes[$urandom_range(0, 4)];
    a  = {$urandom, $urandom};
    b  = ($urandom_range(0, 7) == 0) ? a : {$urandom, $urandom};
    rd = 5'($urandom);
    send(c, a, b, rd, model(c, a, b, rd), budget);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    bus.in_valid = 1'b0;
    while (sb.size() != 0 && n <= budget) begin
      @(negedge clock);
      n++;
    end
    chk("drain_left", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int pops_before;
    checks = 0; failures = 0; pushes = 0; pops = 0;
    rand_bp = 1'b0;
    reset = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_alu_control = '0;
    bus.in_operand_a = '0;
    bus.in_operand_b = '0;
    bus.in_rd = '0;

    repeat (2) @(negedge clock);
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_result", bus.out_result, 64'd0);
    chk("rst_out_zero", 64'(bus.out_zero), 64'd0);
    chk("rst_out_illegal", 64'(bus.out_illegal), 64'd0);
    chk("rst_out_rd", 64'(bus.out_rd), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clock);

    // Directed ops with hand-computed expectations.
    send(ALU_ADD, 64'd5, 64'd7, 5'd3, mk(64'd12, 1'b0, 1'b0, 5'd3), 0);
    send(ALU_SUB, 64'd9, 64'd9, 5'd4, mk(64'd0, 1'b1, 1'b0, 5'd4), 0);
    send(ALU_SUB, 64'd0, 64'd1, 5'd5, mk(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 5'd5), 0);
    send(ALU_AND, 64'hF0F0, 64'hFF00, 5'd6, mk(64'hF000, 1'b0, 1'b0, 5'd6), 0);
    send(ALU_OR, 64'hF0F0, 64'h0F00, 5'd7, mk(64'hFFF0, 1'b0, 1'b0, 5'd7), 0);
    send(4'b1111, 64'h1234, 64'h5678, 5'd8, mk(64'd0, 1'b1, 1'b1, 5'd8), 0);
    send(ALU_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd31, mk(64'd1, 1'b0, 1'b0, 5'd31), 0);
    drain(10);

    // Backpressure: A and B fill the buffer, C waits upstream until out_ready rises.
    bus.out_ready = 1'b0;
    send(ALU_ADD, 64'd100, 64'd1, 5'd10, mk(64'd101, 1'b0, 1'b0, 5'd10), 0);
    send(ALU_OR, 64'h0F, 64'hF0, 5'd11, mk(64'hFF, 1'b0, 1'b0, 5'd11), 0);
    fork
      send(ALU_SUB, 64'd50, 64'd8, 5'd12, mk(64'd42, 1'b0, 1'b0, 5'd12), 20);
      begin
        repeat (4) @(negedge clock);
        bus.out_ready = 1'b1;
      end
    join
    drain(10);

    // Streaming: one op per cycle must be accepted without a stall.
    pops_before = pops;
    for (int i = 0; i < 100; i++) send_rand(0);
    drain(10);
    chk("stream_pops", 64'(pops - pops_before), 64'd100);

    // Random backpressure.
    rand_bp = 1'b1;
    for (int i = 0; i < 80; i++) send_rand(40);
    rand_bp = 1'b0;
    @(negedge clock);
    bus.out_ready = 1'b1;
    drain(10);

    // Reset while FULL discards both entries; an op offered in the reset cycle is ignored.
    bus.out_ready = 1'b0;
    send(ALU_ADD, 64'd1, 64'd2, 5'd1, mk(64'd3, 1'b0, 1'b0, 5'd1), 0);
    send(ALU_ADD, 64'd3, 64'd4, 5'd2, mk(64'd7, 1'b0, 1'b0, 5'd2), 0);
    reset = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_alu_control = ALU_OR;
    bus.in_operand_a = 64'hAA;
    #1;
    chk("rst_full_in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clock);
    sb.delete();
    @(negedge clock);
    reset = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("rst_full_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_full_out_result", bus.out_result, 64'd0);
    chk("rst_full_out_zero", 64'(bus.out_zero), 64'd0);
    chk("rst_full_out_illegal", 64'(bus.out_illegal), 64'd0);
    chk("rst_full_out_rd", 64'(bus.out_rd), 64'd0);
    @(negedge clock);
    send(ALU_ADD, 64'd100, 64'd23, 5'd9, mk(64'd123, 1'b0, 1'b0, 5'd9), 0);
    drain(10);

    repeat (2) @(negedge clock);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
